// File: rtl/regfile_wb_if.sv
// Signal bundle for regfile_wb_arbiter: two writeback sources, the register-file
// write port, and the status seen by the hazard unit.
interface regfile_wb_if #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4
);
   logic                   a_valid;
   logic [4:0]             a_rd;
   logic [DATA_W-1:0]      a_data;
   logic                   a_ready;
   logic                   b_valid;
   logic [4:0]             b_rd;
   logic [DATA_W-1:0]      b_data;
   logic                   b_ready;
   logic                   wr_en;
   logic [4:0]             wr_rd;
   logic [DATA_W-1:0]      wr_data;
   logic [31:0]            pend_mask;
   logic [$clog2(DEPTH):0] fifo_count;

   modport slave (
      input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      output a_ready, b_ready, wr_en, wr_rd, wr_data, pend_mask, fifo_count
   );

   modport master (
      output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      input  a_ready, b_ready, wr_en, wr_rd, wr_data, pend_mask, fifo_count
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Merges in-order pipeline writeback (A) and buffered long-latency results (B)
// onto the single register-file write port, keeping same-register order and bounding B starvation.
module regfile_wb_arbiter #(
   parameter int DATA_W       = 64,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        reset,
   regfile_wb_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [4:0]        fifo_rd   [DEPTH];
   logic [DATA_W-1:0] fifo_data [DEPTH];
   logic [PW-1:0]     wptr, rptr;
   logic [CW-1:0]     count;
   logic [SW-1:0]     starve_cnt;
   logic [31:0]       pend;
   logic              fifo_ne, starved, push, gnt_a, gnt_b, a_rdy, b_rdy;
   logic              wr_en;
   logic [4:0]        wr_rd;
   logic [DATA_W-1:0] wr_data;

   assign fifo_ne = (count != '0);
   assign starved = (starve_cnt == SW'(STARVE_LIMIT));
   assign b_rdy   = (count != CW'(DEPTH));
   // x0 results are acknowledged but never stored, so they cannot reach the port
   assign push    = bus.b_valid && b_rdy && (bus.b_rd != 5'd0);

   // Slot i is live when its distance from the head is below the occupancy.
   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ({1'b0, PW'(i) - rptr} < count)
            pend = pend | (32'd1 << fifo_rd[i]);
      end
   end

   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      a_rdy = 1'b1;
      if (fifo_ne && starved) begin
         gnt_b = 1'b1;
         a_rdy = 1'b0;
      end else if (bus.a_valid && pend[bus.a_rd]) begin
         // An older B write to the same register must land first
         gnt_b = 1'b1;
         a_rdy = 1'b0;
      end else if (bus.a_valid) begin
         gnt_a = 1'b1;
      end else if (fifo_ne) begin
         gnt_b = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         starve_cnt <= '0;
         wr_en      <= 1'b0;
         wr_rd      <= '0;
         wr_data    <= '0;
      end else begin
         if (push)  wptr <= wptr + 1'b1;
         if (gnt_b) rptr <= rptr + 1'b1;
         count <= count + CW'(push) - CW'(gnt_b);

         if (!fifo_ne || gnt_b)
            starve_cnt <= '0;
         else if (gnt_a && !starved)
            starve_cnt <= starve_cnt + 1'b1;

         if (gnt_b) begin
            wr_en   <= 1'b1;
            wr_rd   <= fifo_rd[rptr];
            wr_data <= fifo_data[rptr];
         end else if (gnt_a && (bus.a_rd != 5'd0)) begin
            wr_en   <= 1'b1;
            wr_rd   <= bus.a_rd;
            wr_data <= bus.a_data;
         end else begin
            wr_en   <= 1'b0;
         end
      end
   end

   // Payload storage needs no reset: occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wptr]   <= bus.b_rd;
         fifo_data[wptr] <= bus.b_data;
      end
   end

   assign bus.a_ready    = a_rdy;
   assign bus.b_ready    = b_rdy;
   assign bus.wr_en      = wr_en;
   assign bus.wr_rd      = wr_rd;
   assign bus.wr_data    = wr_data;
   assign bus.pend_mask  = pend;
   assign bus.fifo_count = count;
endmodule
